// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel programmable clock-enable generator.
// Each channel divides the system clock by a runtime-programmable integer
// and produces a one-cycle tick strobe and a square-wave outclk level.
// Any accepted reconfiguration relocks the block. All channels then restart
// from count zero, so they stay phase-aligned. Every output comes straight
// from a flop. The flops are loaded with look-ahead values, so each output
// matches the counter state of the cycle in which it is seen.
module clk_en_gen #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  output logic                cfg_ready,
  output logic [CHANNELS-1:0] outclk,
  output logic [CHANNELS-1:0] tick,
  output logic                locked
);

  localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CH_W:0]   CH_LIMIT = (CH_W + 1)'(CHANNELS);
  localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCK_CYCLES - 1);

  typedef enum logic {
    ST_LOCKING = 1'b0,
    ST_LOCKED  = 1'b1
  } state_t;

  state_t          state_q;
  logic [LC_W-1:0] lock_cnt_q;
  logic            locked_q;
  logic            cfg_ready_q;

  logic cfg_accept;
  logic cfg_hit;
  logic lock_done;
  logic run_next;
  logic start_next;

  // A handshake only counts while we advertise ready. An out-of-range
  // channel index is consumed but leaves the block untouched.
  assign cfg_accept = cfg_valid && cfg_ready_q;
  assign cfg_hit    = cfg_accept && ({1'b0, cfg_ch} < CH_LIMIT);

  // lock_done: the last LOCKING cycle, so the next cycle is the first LOCKED one.
  // run_next: LOCKED now and still LOCKED next cycle, so the counters keep running.
  assign lock_done  = (state_q == ST_LOCKING) && (lock_cnt_q == LOCK_LAST);
  assign run_next   = (state_q == ST_LOCKED) && !cfg_hit;
  assign start_next = lock_done;

  assign locked    = locked_q;
  assign cfg_ready = cfg_ready_q;

  // Lock sequencer: count out the settle time, then run until a valid reconfig.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOCKING;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_LOCKING: begin
          if (lock_done) begin
            state_q     <= ST_LOCKED;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b1;
            cfg_ready_q <= 1'b1;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (cfg_hit) begin
            state_q     <= ST_LOCKING;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
          end
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] d_eff;
    logic [DIV_W-1:0] d_last;
    logic [DIV_W-1:0] d_half;
    logic             outclk_q;
    logic             outclk_d;
    logic             tick_q;
    logic             tick_d;

    // Divisors below 2 cannot make a square wave, so they run as 2.
    assign d_eff  = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
    assign d_last = d_eff - 1'b1;
    assign d_half = d_eff >> 1;

    // Next count: wrap at D-1 while running, otherwise restart from zero.
    always_comb begin
      cnt_d = '0;
      if (run_next) begin
        cnt_d = (cnt_q == d_last) ? '0 : cnt_q + 1'b1;
      end
    end

    // Look-ahead outputs. They are forced low whenever next cycle is LOCKING.
    // The divisor cannot change on a running channel, so d_eff is still valid next cycle.
    assign outclk_d = (run_next || start_next) && (cnt_d < d_half);
    assign tick_d   = (run_next || start_next) && (cnt_d == d_last);

    // Per-channel divisor, phase counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        div_q    <= DIV_W'(DEFAULT_DIV);
        cnt_q    <= '0;
        outclk_q <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        if (cfg_hit && (cfg_ch == CH_W'(gi))) begin
          div_q <= cfg_div;
        end
        cnt_q    <= cnt_d;
        outclk_q <= outclk_d;
        tick_q   <= tick_d;
      end
    end

    assign outclk[gi] = outclk_q;
    assign tick[gi]   = tick_q;
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Testbench for clk_en_gen. Three channels are instantiated so that an
// out-of-range channel index (3) can actually be presented on the 2-bit cfg_ch.
// The stimulus side computes the expected output vector of each cycle from the
// closed-form timing rules: lock point L, phase (c-L) mod D, high while
// phase < D/2, tick at phase D-1. It queues an entry whenever that vector
// changes. The monitor pops an entry each time the DUT outputs change and
// compares both the cycle number and the value.
module tb_clk_en_gen;

  localparam int CH   = 3;
  localparam int LOCK = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_ready;
  logic       locked;
  logic [2:0] outclk;
  logic [2:0] tick;

  always #5 clk = ~clk;

  clk_en_gen #(
    .CHANNELS(CH),
    .DIV_W(8),
    .LOCK_CYCLES(LOCK),
    .DEFAULT_DIV(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_ready(cfg_ready),
    .outclk(outclk),
    .tick(tick),
    .locked(locked)
  );

  typedef struct {
    int         cyc;
    logic [7:0] v;
  } ev_t;

  ev_t        exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         gcyc = 0;        // free-running cycle stamp shared with the monitor
  int         cyc = 0;         // cycle index relative to the last reset release
  int         lock_at = LOCK;  // first LOCKED cycle of the current lock sequence
  int         div_m[CH];
  bit         in_rst = 1'b1;
  bit         accepted = 1'b0;
  logic [7:0] exp_prev = '0;
  logic [7:0] mon_prev = '0;
  logic [7:0] mon_v;
  ev_t        mon_e;

  // Vector layout: {cfg_ready, locked, outclk[2:0], tick[2:0]}
  function automatic logic [7:0] model_vec();
    logic [7:0] r;
    int d;
    int p;
    r = '0;
    if (!in_rst && cyc >= lock_at) begin
      r[7] = 1'b1;
      r[6] = 1'b1;
      for (int c = 0; c < CH; c++) begin
        d = (div_m[c] < 2) ? 2 : div_m[c];
        p = (cyc - lock_at) % d;
        r[3 + c] = (p < d / 2);
        r[c]     = (p == d - 1);
      end
    end
    return r;
  endfunction

  task automatic push_exp();
    logic [7:0] v;
    v = model_vec();
    if (v !== exp_prev) begin
      exp_q.push_back('{cyc: gcyc, v: v});
      exp_prev = v;
    end
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, got, want);
    end
  endtask

  // Advance one clock. Resolve the handshake the edge just sampled, then queue the new expectation.
  task automatic step();
    @(posedge clk);
    #1;
    if (!in_rst && cfg_valid && cyc >= lock_at) begin
      if (int'(cfg_ch) < CH) begin
        div_m[cfg_ch] = int'(cfg_div);
        lock_at = cyc + 1 + LOCK;
      end
      accepted = 1'b1;
      cfg_valid = 1'b0;
    end
    cyc++;
    gcyc++;
    push_exp();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic request(input int ch, input int dv);
    cfg_ch = 2'(ch);
    cfg_div = 8'(dv);
    cfg_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) step();
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_rst = 1'b0;
    cyc = 0;
    lock_at = LOCK;
    for (int c = 0; c < CH; c++) div_m[c] = 2;
    gcyc++;
    push_exp();
  endtask

  // Drop reset between edges so the outputs must clear without a clock.
  task automatic reset_pulse(input int hold);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_rst = 1'b1;
    cfg_valid = 1'b0;
    cyc++;
    gcyc++;
    push_exp();
    #1;
    check("async_reset_outputs", {cfg_ready, locked, outclk, tick}, 8'h00);
    run(hold);
    release_rst();
  endtask

  // Monitor: every change of the DUT outputs must match the next queued event.
  always @(negedge clk) begin
    mon_v = {cfg_ready, locked, outclk, tick};
    if (mon_v !== mon_prev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d got=%b required=no_change", gcyc, mon_v);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != gcyc || mon_e.v !== mon_v) begin
          bad++;
          $display("FAIL event got cyc=%0d v=%b required cyc=%0d v=%b",
                   gcyc, mon_v, mon_e.cyc, mon_e.v);
        end
      end
      mon_prev = mon_v;
    end
  end

  initial begin
    for (int c = 0; c < CH; c++) div_m[c] = 2;
    #2 rst_n = 1'b0;
    run(3);
    check("reset_state", {cfg_ready, locked, outclk, tick}, 8'h00);
    release_rst();

    // Defaults: locked rises at cycle 16, D=2 everywhere.
    run(15);
    check("locked_c15", {7'b0, locked}, 8'h00);
    step();
    check("locked_c16", {7'b0, locked}, 8'h01);
    check("ready_c16", {7'b0, cfg_ready}, 8'h01);
    check("outclk_c16", {5'b0, outclk}, 8'h07);
    step();
    check("tick_c17", {5'b0, tick}, 8'h07);
    run(13);

    // ch1 <- 5: relock after 17 cycles, first tick[1] four cycles after relock.
    request(1, 5);
    check("relock_drop", {7'b0, locked}, 8'h00);
    run(lock_at - 1 - cyc);
    check("locked_before_relock", {7'b0, locked}, 8'h00);
    step();
    check("locked_relock", {7'b0, locked}, 8'h01);
    run(4);
    check("tick_relock_plus4", {5'b0, tick}, 8'h02);
    check("outclk_relock_plus4", {5'b0, outclk}, 8'h05);
    run(30);

    // Divisors 0 and 1 both behave as 2.
    request(1, 0);
    run(40);
    request(1, 1);
    run(40);

    // Largest divisor: 255.
    request(0, 255);
    run(lock_at + 253 - cyc);
    check("tick0_d255_early", {7'b0, tick[0]}, 8'h00);
    step();
    check("tick0_d255", {7'b0, tick[0]}, 8'h01);
    run(260);

    // Out-of-range channel: consumed, nothing relocks.
    request(3, 9);
    run(20);
    check("bad_ch_ready", {7'b0, cfg_ready}, 8'h01);
    check("bad_ch_locked", {7'b0, locked}, 8'h01);

    // A request raised during LOCKING waits for the first locked cycle.
    request(2, 3);
    request(0, 4);
    check("held_req_relock", {7'b0, locked}, 8'h00);
    run(40);

    // Reset mid-LOCKING, then mid-period with D=7.
    request(1, 7);
    run(5);
    reset_pulse(2);
    request(1, 7);
    run(lock_at + 10 - cyc);
    reset_pulse(2);
    run(30);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events got=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
